// File: rtl/clock_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clock_pkg: shared constants and BCD helpers for the clock/date chain |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package clock_pkg;

  localparam int BCD_W = 4;

  localparam logic [1:0] SEL_DAY   = 2'b00;
  localparam logic [1:0] SEL_MONTH = 2'b01;
  localparam logic [1:0] SEL_YEAR  = 2'b10;
  localparam logic [1:0] SEL_NONE  = 2'b11;

  localparam logic [2*BCD_W-1:0] RST_DAY   = 8'h01;
  localparam logic [2*BCD_W-1:0] RST_MONTH = 8'h01;

  localparam logic [BCD_W-1:0] RST_YEAR_THOU_DEF = 4'd2;
  localparam logic [BCD_W-1:0] RST_YEAR_HUND_DEF = 4'd0;
  localparam logic [BCD_W-1:0] RST_YEAR_TEN_DEF  = 4'd0;
  localparam logic [BCD_W-1:0] RST_YEAR_UNIT_DEF = 4'd0;

  // Two-digit BCD value divisible by 4, decided without binary conversion.
  function automatic logic div4_bcd(input logic [BCD_W-1:0] ten, input logic [BCD_W-1:0] unit);
    if (ten[0]) return (unit == 4'd2) || (unit == 4'd6);
    return (unit == 4'd0) || (unit == 4'd4) || (unit == 4'd8);
  endfunction

  function automatic logic is_leap_bcd(input logic [BCD_W-1:0] thou, input logic [BCD_W-1:0] hund,
                                       input logic [BCD_W-1:0] ten,  input logic [BCD_W-1:0] unit);
    if ((ten == 4'd0) && (unit == 4'd0)) return div4_bcd(thou, hund);
    return div4_bcd(ten, unit);
  endfunction

  function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd2_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Four-digit ripple; 9999 wraps to 0000 naturally.
  function automatic logic [15:0] bcd4_inc(input logic [15:0] v);
    logic [15:0] v_res;
    logic        v_carry;
    v_res   = v;
    v_carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (v_carry) begin
        if (v_res[i*4 +: 4] == 4'd9) begin
          v_res[i*4 +: 4] = 4'd0;
        end else begin
          v_res[i*4 +: 4] = v_res[i*4 +: 4] + 4'd1;
          v_carry         = 1'b0;
        end
      end
    end
    return v_res;
  endfunction

  function automatic logic [15:0] bcd4_dec(input logic [15:0] v);
    logic [15:0] v_res;
    logic        v_borrow;
    v_res    = v;
    v_borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (v_borrow) begin
        if (v_res[i*4 +: 4] == 4'd0) begin
          v_res[i*4 +: 4] = 4'd9;
        end else begin
          v_res[i*4 +: 4] = v_res[i*4 +: 4] - 4'd1;
          v_borrow        = 1'b0;
        end
      end
    end
    return v_res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/counter_date_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | counter_date_if: control inputs and BCD date outputs of counter_date |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface counter_date_if;
  logic       mode_date;
  logic       tick_day;
  logic       up;
  logic       down;
  logic [1:0] sel_field;
  logic [3:0] day_unit;
  logic [3:0] day_ten;
  logic [3:0] month_unit;
  logic [3:0] month_ten;
  logic [3:0] year_unit;
  logic [3:0] year_ten;
  logic [3:0] year_hund;
  logic [3:0] year_thou;
  logic       tick_year;

  modport master (
    output mode_date, tick_day, up, down, sel_field,
    input  day_unit, day_ten, month_unit, month_ten,
           year_unit, year_ten, year_hund, year_thou, tick_year
  );

  modport slave (
    input  mode_date, tick_day, up, down, sel_field,
    output day_unit, day_ten, month_unit, month_ten,
           year_unit, year_ten, year_hund, year_thou, tick_year
  );
endinterface
`default_nettype wire

// File: rtl/date_days_in_month.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | date_days_in_month: BCD month + leap flag -> last day of month (BCD) |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module date_days_in_month
  import clock_pkg::*;
(
  input  wire logic [BCD_W-1:0] i_month_ten,
  input  wire logic [BCD_W-1:0] i_month_unit,
  input  wire logic             i_leap,
  output logic      [BCD_W-1:0] o_max_ten,
  output logic      [BCD_W-1:0] o_max_unit
);

  always_comb begin
    o_max_ten  = 4'd3;
    o_max_unit = 4'd1;
    case ({i_month_ten, i_month_unit})
      8'h02: begin
        o_max_ten  = 4'd2;
        o_max_unit = i_leap ? 4'd9 : 4'd8;
      end
      8'h04, 8'h06, 8'h09, 8'h11: begin
        o_max_ten  = 4'd3;
        o_max_unit = 4'd0;
      end
      default: begin
        o_max_ten  = 4'd3;
        o_max_unit = 4'd1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/counter_date.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | counter_date: BCD calendar DD/MM/YYYY driven by tick_day, with       |
// | per-field manual adjust. Rev 1.0                                     |
// +----------------------------------------------------------------------+
module counter_date
  import clock_pkg::*;
#(
  parameter logic [BCD_W-1:0] RST_YEAR_THOU = RST_YEAR_THOU_DEF,
  parameter logic [BCD_W-1:0] RST_YEAR_HUND = RST_YEAR_HUND_DEF,
  parameter logic [BCD_W-1:0] RST_YEAR_TEN  = RST_YEAR_TEN_DEF,
  parameter logic [BCD_W-1:0] RST_YEAR_UNIT = RST_YEAR_UNIT_DEF
)
(
  input  wire logic      clk,
  input  wire logic      rst_n,
  counter_date_if.slave  bus
);

  localparam logic [15:0] c_RST_YEAR = {RST_YEAR_THOU, RST_YEAR_HUND, RST_YEAR_TEN, RST_YEAR_UNIT};

  logic [7:0]  r_day;
  logic [7:0]  r_month;
  logic [15:0] r_year;
  logic        r_tick_year;

  logic        w_cur_leap;
  logic [7:0]  w_cur_max;
  logic        w_adj_one;
  logic [7:0]  w_tgt_month;
  logic [15:0] w_tgt_year;
  logic        w_tgt_leap;
  logic [7:0]  w_tgt_max;
  logic [7:0]  w_day_nxt;
  logic [7:0]  w_month_nxt;
  logic [15:0] w_year_nxt;
  logic        w_tick_nxt;

  assign w_cur_leap = is_leap_bcd(r_year[15:12], r_year[11:8], r_year[7:4], r_year[3:0]);

  date_days_in_month u_cur_max (
    .i_month_ten  (r_month[7:4]),
    .i_month_unit (r_month[3:0]),
    .i_leap       (w_cur_leap),
    .o_max_ten    (w_cur_max[7:4]),
    .o_max_unit   (w_cur_max[3:0])
  );

  // Month/year the adjust would produce; feeds the day clamp in the same cycle.
  always_comb begin
    w_adj_one   = !bus.mode_date && (bus.up ^ bus.down) && (bus.sel_field != SEL_NONE);
    w_tgt_month = r_month;
    w_tgt_year  = r_year;
    if (w_adj_one && (bus.sel_field == SEL_MONTH)) begin
      if (bus.up) w_tgt_month = (r_month == 8'h12) ? 8'h01 : bcd2_inc(r_month);
      else        w_tgt_month = (r_month == 8'h01) ? 8'h12 : bcd2_dec(r_month);
    end
    if (w_adj_one && (bus.sel_field == SEL_YEAR)) begin
      w_tgt_year = bus.up ? bcd4_inc(r_year) : bcd4_dec(r_year);
    end
    w_tgt_leap = is_leap_bcd(w_tgt_year[15:12], w_tgt_year[11:8], w_tgt_year[7:4], w_tgt_year[3:0]);
  end

  date_days_in_month u_tgt_max (
    .i_month_ten  (w_tgt_month[7:4]),
    .i_month_unit (w_tgt_month[3:0]),
    .i_leap       (w_tgt_leap),
    .o_max_ten    (w_tgt_max[7:4]),
    .o_max_unit   (w_tgt_max[3:0])
  );

  always_comb begin
    w_day_nxt   = r_day;
    w_month_nxt = r_month;
    w_year_nxt  = r_year;
    w_tick_nxt  = 1'b0;
    if (bus.mode_date) begin
      if (bus.tick_day) begin
        if (r_day != w_cur_max) begin
          w_day_nxt = bcd2_inc(r_day);
        end else if (r_month != 8'h12) begin
          w_day_nxt   = 8'h01;
          w_month_nxt = bcd2_inc(r_month);
        end else begin
          w_day_nxt   = 8'h01;
          w_month_nxt = 8'h01;
          w_year_nxt  = bcd4_inc(r_year);
          w_tick_nxt  = 1'b1;
        end
      end
    end else if (w_adj_one) begin
      if (bus.sel_field == SEL_DAY) begin
        if (bus.up) w_day_nxt = (r_day == w_cur_max) ? 8'h01 : bcd2_inc(r_day);
        else        w_day_nxt = (r_day == 8'h01) ? w_cur_max : bcd2_dec(r_day);
      end else begin
        // Packed BCD orders like binary, so a plain compare gives min().
        w_month_nxt = w_tgt_month;
        w_year_nxt  = w_tgt_year;
        w_day_nxt   = (r_day > w_tgt_max) ? w_tgt_max : r_day;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_day       <= RST_DAY;
      r_month     <= RST_MONTH;
      r_year      <= c_RST_YEAR;
      r_tick_year <= 1'b0;
    end else begin
      r_day       <= w_day_nxt;
      r_month     <= w_month_nxt;
      r_year      <= w_year_nxt;
      r_tick_year <= w_tick_nxt;
    end
  end

  assign bus.day_ten    = r_day[7:4];
  assign bus.day_unit   = r_day[3:0];
  assign bus.month_ten  = r_month[7:4];
  assign bus.month_unit = r_month[3:0];
  assign bus.year_thou  = r_year[15:12];
  assign bus.year_hund  = r_year[11:8];
  assign bus.year_ten   = r_year[7:4];
  assign bus.year_unit  = r_year[3:0];
  assign bus.tick_year  = r_tick_year;

endmodule
`default_nettype wire

// File: tb/tb_counter_date.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_counter_date: directed self-checking bench for counter_date       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_counter_date;
  import clock_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cur_d, cur_m, cur_y;

  counter_date_if bus();

  counter_date dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] to_bcd4(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check_date(input string tag, input int d, input int m, input int y);
    logic [31:0] obs;
    logic [31:0] exp;
    obs = {bus.day_ten, bus.day_unit, bus.month_ten, bus.month_unit,
           bus.year_thou, bus.year_hund, bus.year_ten, bus.year_unit};
    exp = {to_bcd2(d), to_bcd2(m), to_bcd4(y)};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s date observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_tick(input string tag, input logic exp);
    checks++;
    assert (bus.tick_year === exp) else begin
      errors++;
      $error("FAIL %s tick_year observed=%b expected=%b", tag, bus.tick_year, exp);
    end
  endtask

  task automatic press(input logic u, input logic d, input logic [1:0] sel);
    @(negedge clk);
    bus.mode_date = 1'b0;
    bus.up        = u;
    bus.down      = d;
    bus.sel_field = sel;
    @(negedge clk);
    bus.up        = 1'b0;
    bus.down      = 1'b0;
    bus.sel_field = SEL_NONE;
  endtask

  task automatic tick();
    @(negedge clk);
    bus.mode_date = 1'b1;
    bus.tick_day  = 1'b1;
    @(negedge clk);
    bus.tick_day  = 1'b0;
  endtask

  // Walks the date to a target with day parked at 01 so no clamp interferes.
  task automatic set_date(input int d, input int m, input int y);
    int diff;
    for (int i = 0; i < cur_d - 1; i++) press(1'b0, 1'b1, SEL_DAY);
    diff = (y - cur_y + 10000) % 10000;
    if (diff <= 5000) for (int i = 0; i < diff; i++) press(1'b1, 1'b0, SEL_YEAR);
    else              for (int i = 0; i < 10000 - diff; i++) press(1'b0, 1'b1, SEL_YEAR);
    diff = (m - cur_m + 12) % 12;
    for (int i = 0; i < diff; i++) press(1'b1, 1'b0, SEL_MONTH);
    for (int i = 0; i < d - 1; i++) press(1'b1, 1'b0, SEL_DAY);
    cur_d = d; cur_m = m; cur_y = y;
    check_date("set_date", d, m, y);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    bus.mode_date = 1'b1;
    bus.tick_day  = 1'b0;
    bus.up        = 1'b0;
    bus.down      = 1'b0;
    bus.sel_field = SEL_NONE;
    repeat (2) @(negedge clk);
    check_date("reset", 1, 1, 2000);
    check_tick("reset", 1'b0);
    rst_n = 1'b1;
    cur_d = 1; cur_m = 1; cur_y = 2000;

    // January run-through
    for (int i = 0; i < 31; i++) begin
      tick();
      check_tick("jan_run", 1'b0);
    end
    check_date("jan_to_feb", 1, 2, 2000);
    cur_d = 1; cur_m = 2;

    // Leap-year rules at end of February
    set_date(28, 2, 2000);
    tick();
    check_date("leap_2000", 29, 2, 2000);
    cur_d = 29;
    set_date(28, 2, 1900);
    tick();
    check_date("noleap_1900", 1, 3, 1900);
    cur_d = 1; cur_m = 3;
    set_date(28, 2, 2023);
    tick();
    check_date("noleap_2023", 1, 3, 2023);
    cur_d = 1; cur_m = 3;

    // Year rollovers
    set_date(31, 12, 9999);
    tick();
    check_date("wrap_9999", 1, 1, 0);
    check_tick("wrap_9999_pulse", 1'b1);
    @(negedge clk);
    check_tick("wrap_9999_clear", 1'b0);
    cur_d = 1; cur_m = 1; cur_y = 0;
    set_date(31, 12, 2099);
    tick();
    check_date("roll_2099", 1, 1, 2100);
    check_tick("roll_2099_pulse", 1'b1);
    @(negedge clk);
    check_tick("roll_2099_clear", 1'b0);
    cur_d = 1; cur_m = 1; cur_y = 2100;

    // Day adjust wrap and no-op cases
    set_date(1, 4, 2100);
    press(1'b0, 1'b1, SEL_DAY);
    check_date("day_down_wrap", 30, 4, 2100);
    press(1'b1, 1'b0, SEL_DAY);
    check_date("day_up_wrap", 1, 4, 2100);
    press(1'b1, 1'b1, SEL_DAY);
    check_date("day_both", 1, 4, 2100);
    press(1'b1, 1'b0, SEL_NONE);
    check_date("sel_none", 1, 4, 2100);
    check_tick("adjust_tick", 1'b0);

    // Clamp on month/year adjust
    set_date(31, 1, 2023);
    press(1'b1, 1'b0, SEL_MONTH);
    check_date("clamp_month_up", 28, 2, 2023);
    cur_d = 28; cur_m = 2;
    set_date(29, 2, 2024);
    press(1'b1, 1'b0, SEL_YEAR);
    check_date("clamp_year_up", 28, 2, 2025);
    cur_d = 28; cur_y = 2025;
    set_date(31, 3, 2025);
    press(1'b0, 1'b1, SEL_MONTH);
    check_date("clamp_month_down", 28, 2, 2025);
    cur_d = 28; cur_m = 2;

    // tick_day dropped in adjust mode
    @(negedge clk);
    bus.mode_date = 1'b0;
    bus.tick_day  = 1'b1;
    @(negedge clk);
    bus.tick_day  = 1'b0;
    check_date("adjust_tick_day", 28, 2, 2025);
    check_tick("adjust_tick_day", 1'b0);

    // Async reset while tick_year is high and tick_day still pending
    set_date(31, 12, 2099);
    @(negedge clk);
    bus.mode_date = 1'b1;
    bus.tick_day  = 1'b1;
    @(negedge clk);
    check_date("pre_reset", 1, 1, 2100);
    check_tick("pre_reset", 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check_date("async_reset", 1, 1, 2000);
    check_tick("async_reset", 1'b0);
    @(negedge clk);
    bus.tick_day = 1'b0;
    rst_n        = 1'b1;
    @(negedge clk);
    check_date("after_reset", 1, 1, 2000);
    check_tick("after_reset", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
